// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program-counter and instruction-fetch sequencer for an RV64I
//            core. Computes the next PC from the control-transfer code,
//            traps misaligned branch/jump targets, runs a request/ready
//            handshake with instruction memory, holds the fetched
//            instruction until commit, and counts retired instructions.
// Ports    :
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   pc_sel[1:0]        - 00 pc+4, 01 pc+imm, 10 jalr, 11 trap vector
//   imm[63:0]          - sign-extended immediate
//   alu_result[63:0]   - jalr target before bit-0 masking
//   advance            - core commits the held instruction
//   imem_ready         - instruction memory data valid
//   imem_rdata[31:0]   - instruction word
//   imem_req           - fetch request
//   imem_addr[63:0]    - fetch address (equals pc)
//   pc[63:0]           - PC of the held/fetched instruction
//   pc_plus_4[63:0]    - pc + 4, for link registers
//   inst[31:0]         - held instruction
//   inst_valid         - inst is valid for execution
//   misaligned_trap    - one-cycle pulse on a misaligned target
//   trap_epc[63:0]     - PC of the instruction with the misaligned target
//   instret[63:0]      - retired instruction count
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0040_0000,
  parameter logic [63:0] TRAP_VECTOR  = 64'h0000_0000_0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pc_sel,
  input  logic [63:0] imm,
  input  logic [63:0] alu_result,
  input  logic        advance,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic [63:0] pc,
  output logic [63:0] pc_plus_4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        misaligned_trap,
  output logic [63:0] trap_epc,
  output logic [63:0] instret
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        w_commit;
  logic [63:0] w_branch_target;
  logic [63:0] w_jalr_target;
  logic [63:0] w_next_pc;
  logic        w_misaligned;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    inst_valid   = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (advance) begin
          w_commit     = 1'b1;
          w_state_next = REQ;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-PC selection; only consumed when w_commit is high
  // --------------------------------------------------------------------------
  assign w_branch_target = pc + imm;
  assign w_jalr_target   = alu_result & ~64'h1;

  always_comb begin
    w_next_pc    = pc + 64'd4;
    w_misaligned = 1'b0;
    unique case (pc_sel)
      2'b00: begin
        w_next_pc = pc + 64'd4;
      end
      2'b01: begin
        if (w_branch_target[1:0] != 2'b00) begin
          w_next_pc    = TRAP_VECTOR;
          w_misaligned = 1'b1;
        end else begin
          w_next_pc = w_branch_target;
        end
      end
      2'b10: begin
        // bit 0 is already cleared, so only bit 1 can make this misaligned
        if (w_jalr_target[1:0] != 2'b00) begin
          w_next_pc    = TRAP_VECTOR;
          w_misaligned = 1'b1;
        end else begin
          w_next_pc = w_jalr_target;
        end
      end
      2'b11: begin
        w_next_pc = TRAP_VECTOR;
      end
      default: begin
        w_next_pc = pc + 64'd4;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pc              <= RESET_VECTOR;
      inst            <= 32'h0;
      misaligned_trap <= 1'b0;
      trap_epc        <= 64'h0;
      instret         <= 64'h0;
    end else begin
      misaligned_trap <= 1'b0;
      if ((r_state == REQ) && imem_ready) begin
        inst <= imem_rdata;
      end
      if (w_commit) begin
        pc      <= w_next_pc;
        instret <= instret + 64'd1;
        if (w_misaligned) begin
          misaligned_trap <= 1'b1;
          trap_epc        <= pc;
        end
      end
    end
  end

  assign imem_addr = pc;
  assign pc_plus_4 = pc + 64'd4;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit. A behavioural model of
//            the fetch protocol is compared with the DUT on every cycle,
//            and directed steps pin selected values with literal
//            expectations before a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [63:0] RV = 64'h0000_0000_0040_0000;
  localparam logic [63:0] TV = 64'h0000_0000_0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pc_sel = 2'b00;
  logic [63:0] imm = 64'h0;
  logic [63:0] alu_result = 64'h0;
  logic        advance = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [63:0] pc;
  logic [63:0] pc_plus_4;
  logic [31:0] inst;
  logic        inst_valid;
  logic        misaligned_trap;
  logic [63:0] trap_epc;
  logic [63:0] instret;

  pc_fetch_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_sel         (pc_sel),
    .imm            (imm),
    .alu_result     (alu_result),
    .advance        (advance),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .pc             (pc),
    .pc_plus_4      (pc_plus_4),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .misaligned_trap(misaligned_trap),
    .trap_epc       (trap_epc),
    .instret        (instret)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: the unit is either waiting a cycle after reset,
  // fetching, or holding an instruction.
  // --------------------------------------------------------------------------
  bit          m_init = 0;
  bit          m_fetching;
  bit          m_holding;
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic [63:0] m_instret;
  bit          m_trap;
  logic [63:0] m_epc;

  always @(posedge clock) begin
    logic [63:0] target;
    if (reset) begin
      m_init     = 1;
      m_fetching = 0;
      m_holding  = 0;
      m_pc       = RV;
      m_inst     = 32'h0;
      m_instret  = 64'h0;
      m_trap     = 0;
      m_epc      = 64'h0;
    end else if (m_init) begin
      m_trap = 0;
      if (!m_fetching && !m_holding) begin
        m_fetching = 1;
      end else if (m_fetching) begin
        if (imem_ready) begin
          m_inst     = imem_rdata;
          m_fetching = 0;
          m_holding  = 1;
        end
      end else if (advance) begin
        case (pc_sel)
          2'd0:    target = m_pc + 64'd4;
          2'd1:    target = m_pc + imm;
          2'd2:    target = {alu_result[63:1], 1'b0};
          default: target = TV;
        endcase
        if ((pc_sel == 2'd1 || pc_sel == 2'd2) && (target % 4 != 0)) begin
          m_trap = 1;
          m_epc  = m_pc;
          target = TV;
        end
        m_pc       = target;
        m_instret  = m_instret + 64'd1;
        m_holding  = 0;
        m_fetching = 1;
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clock) begin
    if (m_init) begin
      chk("imem_req",        {63'h0, imem_req},        {63'h0, m_fetching});
      chk("imem_addr",       imem_addr,                m_pc);
      chk("pc",              pc,                       m_pc);
      chk("pc_plus_4",       pc_plus_4,                m_pc + 64'd4);
      chk("inst",            {32'h0, inst},            {32'h0, m_inst});
      chk("inst_valid",      {63'h0, inst_valid},      {63'h0, m_holding});
      chk("misaligned_trap", {63'h0, misaligned_trap}, {63'h0, m_trap});
      chk("trap_epc",        trap_epc,                 m_epc);
      chk("instret",         instret,                  m_instret);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: each tick returns just after a falling edge
  // --------------------------------------------------------------------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic commit(input logic [1:0] sel, input logic [63:0] im, input logic [63:0] alu);
    pc_sel     = sel;
    imm        = im;
    alu_result = alu;
    advance    = 1'b1;
    tick();
    advance    = 1'b0;
  endtask

  logic [63:0] saved_pc;
  logic [63:0] saved_ret;

  initial begin
    // reset, then first fetch
    reset = 1'b1;
    tick();
    tick();
    chk("rst_pc",      pc, RV);
    chk("rst_instret", instret, 64'h0);
    chk("rst_req",     {63'h0, imem_req}, 64'h0);
    reset      = 1'b0;
    imem_ready = 1'b1;          // ignored while IDLE
    imem_rdata = 32'h0000_0013;
    tick();
    chk("req_addr",    imem_addr, 64'h400000);
    chk("req_asserted", {63'h0, imem_req}, 64'h1);
    tick();
    imem_ready = 1'b0;
    chk("first_inst",  {32'h0, inst}, 64'h13);
    chk("first_valid", {63'h0, inst_valid}, 64'h1);
    chk("first_ret",   instret, 64'h0);

    // sequential commits
    commit(2'b00, 64'h0, 64'h0);
    chk("seq1_pc", pc, 64'h400004);
    chk("seq1_model_pc", m_pc, 64'h400004);
    chk("seq1_valid", {63'h0, inst_valid}, 64'h0);
    fetch(32'h0010_0093);
    commit(2'b00, 64'h0, 64'h0);
    chk("seq2_pc", pc, 64'h400008);
    fetch(32'h0020_0113);
    commit(2'b00, 64'h0, 64'h0);
    chk("seq3_pc", pc, 64'h40000C);
    chk("seq3_ret", instret, 64'd3);
    chk("seq3_model_ret", m_instret, 64'd3);
    fetch(32'h0030_0193);
    commit(2'b00, 64'h0, 64'h0);
    chk("seq4_pc", pc, 64'h400010);
    fetch(32'h0000_0063);

    // branch back, branch forward, misaligned jalr
    commit(2'b01, -64'sd16, 64'h0);
    chk("br_pc", pc, 64'h400000);
    fetch(32'h0000_0063);
    commit(2'b01, 64'd16, 64'h0);
    chk("br2_pc", pc, 64'h400010);
    fetch(32'h0000_0067);
    commit(2'b10, 64'h0, 64'h500003);
    chk("jalr_pc",   pc, 64'h1000);
    chk("jalr_epc",  trap_epc, 64'h400010);
    chk("jalr_trap", {63'h0, misaligned_trap}, 64'h1);
    chk("jalr_model_epc", m_epc, 64'h400010);
    tick();
    chk("jalr_trap_gone", {63'h0, misaligned_trap}, 64'h0);

    // memory wait with a stray advance during REQ
    saved_pc  = pc;
    saved_ret = instret;
    advance   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait_req",  {63'h0, imem_req}, 64'h1);
      chk("wait_addr", imem_addr, saved_pc);
    end
    advance = 1'b0;
    chk("wait_pc",  pc, saved_pc);
    chk("wait_ret", instret, saved_ret);
    fetch(32'h0000_0013);

    // trap vector select: retires, no pulse
    commit(2'b11, 64'h0, 64'h0);
    chk("trapsel_pc",   pc, TV);
    chk("trapsel_trap", {63'h0, misaligned_trap}, 64'h0);
    fetch(32'h0000_0013);

    // wrap-around
    commit(2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_setup", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_link",  pc_plus_4, 64'h0);
    fetch(32'h0000_0013);
    commit(2'b00, 64'h0, 64'h0);
    chk("wrap_pc", pc, 64'h0);

    // reset mid-REQ, late ready afterwards
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    imem_ready = 1'b1;
    chk("midrst_pc",    pc, RV);
    chk("midrst_req",   {63'h0, imem_req}, 64'h0);
    chk("midrst_valid", {63'h0, inst_valid}, 64'h0);
    tick();
    imem_ready = 1'b0;
    chk("late_ready_valid", {63'h0, inst_valid}, 64'h0);
    chk("late_ready_pc",    pc, RV);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 79) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      imem_rdata = $urandom;
      advance    = ($urandom_range(0, 2) != 0);
      pc_sel     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        imm = {$urandom, $urandom};
      else
        imm = 64'($signed(32'($urandom_range(0, 255)) - 32'sd128));
      alu_result = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
